mem_wb_writeback: RTL and testbench

- MEM/WB pipeline register and writeback unit for the 5-stage RV32I pipeline.
- Accepts retiring instructions from MEM and waits for variable-latency data-memory load responses, stalling upstream while it waits.
- Extracts and sign- or zero-extends load data, and drives the register-file write port (RegWrite_wb, rd_wb, wb_data_wb) consumed by the decode stage.
- Keeps a retired-instruction counter and error flags.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/load_align.sv | 45 ++++
 rtl/mem_wb_writeback.sv | 112 +++++++++++
 tb/tb_mem_wb_writeback.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and writeback-stage state type.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed byte/half of an aligned word and extends it.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'h0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {16'h0, half_sel};
                misaligned = addr[0];
            end
            // LW and every unused encoding take the whole word
            default: misaligned = (addr != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: waits on data-memory loads, extends load data and
// drives the register-file write port, plus retire counter and error flags.
module mem_wb_writeback
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_m,
    input  logic             RegWrite_m,
    input  logic             MemRead_m,
    input  logic             MemToReg_m,
    input  logic [4:0]       rd_m,
    input  logic [2:0]       funct3_m,
    input  logic [31:0]      alu_result_m,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             stall_out,
    output logic             RegWrite_wb,
    output logic [4:0]       rd_wb,
    output logic [31:0]      wb_data_wb,
    output logic             misalign_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instret_count,
    output logic             state_dbg
);

    // Handshake: MEM offers an instruction with valid_m; this stage accepts it
    // on any edge where valid_m=1 and stall_out=0. While stall_out=1 MEM must
    // hold valid_m and all *_m fields stable.

    localparam int CW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_e   state;
    logic [CW-1:0] wait_cnt;

    logic        is_load;
    logic        timeout_fire;
    logic        abandon;
    logic        capture;
    logic [31:0] ld_data;
    logic        ld_misaligned;
    logic        mis_load;
    logic [31:0] wdata_next;

    load_align u_load_align (
        .funct3     (funct3_m),
        .addr       (alu_result_m[1:0]),
        .rdata      (dmem_rdata),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    assign is_load      = valid_m & MemRead_m;
    assign timeout_fire = (state == WB_LOAD_WAIT) && (wait_cnt == CNT_LAST);
    assign stall_out    = rst & is_load & ~dmem_rvalid & ~timeout_fire;
    // A timed-out load leaves MEM (stall drops) but must not be written back
    assign abandon      = timeout_fire & ~dmem_rvalid;
    assign capture      = valid_m & ~stall_out & ~abandon;
    assign mis_load     = is_load & ld_misaligned;
    assign wdata_next   = MemToReg_m ? ld_data : alu_result_m;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WB_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    wait_cnt <= '0;
                    if (is_load && !dmem_rvalid)
                        state <= WB_LOAD_WAIT;
                end
                default: begin
                    if (!is_load || dmem_rvalid || timeout_fire) begin
                        state    <= WB_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite_wb   <= 1'b0;
            rd_wb         <= 5'd0;
            wb_data_wb    <= 32'd0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
            instret_count <= '0;
        end else begin
            RegWrite_wb  <= capture & RegWrite_m & ~mis_load & (rd_m != 5'd0);
            misalign_err <= capture & mis_load;
            if (capture) begin
                rd_wb      <= rd_m;
                wb_data_wb <= wdata_next;
            end
            if (abandon)
                timeout_err <= 1'b1;
            if (capture || abandon)
                instret_count <= instret_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback with LOAD_TIMEOUT=4.
module tb_mem_wb_writeback;

    logic        clk;
    logic        rst;
    logic        valid_m, RegWrite_m, MemRead_m, MemToReg_m;
    logic [4:0]  rd_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out, RegWrite_wb, misalign_err, timeout_err, state_dbg;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data_wb;
    logic [63:0] instret_count;

    int n_vec;
    int n_err;

    mem_wb_writeback #(.LOAD_TIMEOUT(4), .CNT_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_m       (valid_m),
        .RegWrite_m    (RegWrite_m),
        .MemRead_m     (MemRead_m),
        .MemToReg_m    (MemToReg_m),
        .rd_m          (rd_m),
        .funct3_m      (funct3_m),
        .alu_result_m  (alu_result_m),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .stall_out     (stall_out),
        .RegWrite_wb   (RegWrite_wb),
        .rd_wb         (rd_wb),
        .wb_data_wb    (wb_data_wb),
        .misalign_err  (misalign_err),
        .timeout_err   (timeout_err),
        .instret_count (instret_count),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_m = 0; RegWrite_m = 0; MemRead_m = 0; MemToReg_m = 0;
        rd_m = 0; funct3_m = 0; alu_result_m = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        valid_m = 1; RegWrite_m = 1; MemRead_m = 0; MemToReg_m = 0;
        rd_m = rd; funct3_m = 3'b000; alu_result_m = res; dmem_rvalid = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rdata,
                              input logic rv);
        valid_m = 1; RegWrite_m = 1; MemRead_m = 1; MemToReg_m = 1;
        rd_m = rd; funct3_m = f3; alu_result_m = addr;
        dmem_rdata = rdata; dmem_rvalid = rv;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 0;
        drive_idle();
        tick();
        tick();
        chk("rst_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("rst_rd", 64'(rd_wb), 64'd0);
        chk("rst_data", 64'(wb_data_wb), 64'd0);
        chk("rst_instret", instret_count, 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        rst = 1;
        tick();

        // ALU op
        drive_alu(5'd5, 32'h1234_5678);
        #1 chk("alu_stall", 64'(stall_out), 64'd0);
        tick();
        chk("alu_regwrite", 64'(RegWrite_wb), 64'd1);
        chk("alu_rd", 64'(rd_wb), 64'd5);
        chk("alu_data", 64'(wb_data_wb), 64'h1234_5678);
        chk("alu_instret", instret_count, 64'd1);

        // Zero-wait LB then LBU of byte 3
        drive_load(5'd7, 3'b000, 32'h0000_0103, 32'h80AA_BBCC, 1'b1);
        #1 chk("lb_stall", 64'(stall_out), 64'd0);
        tick();
        chk("lb_data", 64'(wb_data_wb), 64'hFFFF_FF80);
        chk("lb_regwrite", 64'(RegWrite_wb), 64'd1);
        chk("lb_rd", 64'(rd_wb), 64'd7);
        drive_load(5'd8, 3'b100, 32'h0000_0103, 32'h80AA_BBCC, 1'b1);
        tick();
        chk("lbu_data", 64'(wb_data_wb), 64'h0000_0080);
        chk("lbu_instret", instret_count, 64'd3);

        // LHU with data on the 4th cycle
        drive_load(5'd9, 3'b101, 32'h0000_0202, 32'hF00D_1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lhu_stall", 64'(stall_out), 64'd1);
            tick();
            chk("lhu_bubble", 64'(RegWrite_wb), 64'd0);
        end
        dmem_rvalid = 1;
        #1 chk("lhu_stall_release", 64'(stall_out), 64'd0);
        tick();
        chk("lhu_data", 64'(wb_data_wb), 64'h0000_F00D);
        chk("lhu_rd", 64'(rd_wb), 64'd9);
        chk("lhu_regwrite", 64'(RegWrite_wb), 64'd1);
        chk("lhu_instret", instret_count, 64'd4);
        chk("lhu_state", 64'(state_dbg), 64'd0);

        // Timeout: no rvalid ever
        drive_load(5'd10, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_stall", 64'(stall_out), 64'd1);
            tick();
        end
        #1 chk("to_stall_drop", 64'(stall_out), 64'd0);
        tick();
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("to_rd_hold", 64'(rd_wb), 64'd9);
        chk("to_instret", instret_count, 64'd5);
        drive_idle();
        dmem_rvalid = 1;
        dmem_rdata = 32'h5555_5555;
        tick();
        chk("stray_rvalid_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("stray_rvalid_instret", instret_count, 64'd5);
        chk("to_err_sticky", 64'(timeout_err), 64'd1);

        // Misaligned LW, then x0 write
        drive_load(5'd11, 3'b010, 32'h0000_0302, 32'h1111_2222, 1'b1);
        tick();
        chk("mis_err", 64'(misalign_err), 64'd1);
        chk("mis_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("mis_instret", instret_count, 64'd6);
        drive_alu(5'd0, 32'h0000_00AA);
        tick();
        chk("mis_err_pulse", 64'(misalign_err), 64'd0);
        chk("x0_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("x0_instret", instret_count, 64'd7);

        // Reset in the middle of a load wait
        drive_load(5'd12, 3'b010, 32'h0000_0500, 32'h0, 1'b0);
        tick();
        tick();
        chk("pre_rst_state", 64'(state_dbg), 64'd1);
        rst = 0;
        #1;
        chk("arst_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("arst_rd", 64'(rd_wb), 64'd0);
        chk("arst_data", 64'(wb_data_wb), 64'd0);
        chk("arst_instret", instret_count, 64'd0);
        chk("arst_timeout", 64'(timeout_err), 64'd0);
        chk("arst_stall", 64'(stall_out), 64'd0);
        chk("arst_state", 64'(state_dbg), 64'd0);
        tick();
        drive_idle();
        dmem_rvalid = 1;
        rst = 1;
        tick();
        chk("post_rst_regwrite", 64'(RegWrite_wb), 64'd0);
        chk("post_rst_instret", instret_count, 64'd0);
        drive_alu(5'd13, 32'hCAFE_F00D);
        tick();
        chk("post_rst_alu_regwrite", 64'(RegWrite_wb), 64'd1);
        chk("post_rst_alu_rd", 64'(rd_wb), 64'd13);
        chk("post_rst_alu_data", 64'(wb_data_wb), 64'hCAFE_F00D);
        chk("post_rst_alu_instret", instret_count, 64'd1);
        drive_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
